sprite_renderer: RTL and testbench
==================================

SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 Parameter PLAYER_Y, default 440: top row of player sprite.
REQ-002 Parameter SPR_W / SPR_H, default 16 / 16: player and enemy sprite size in pixels.
REQ-003 Parameter ENEMY_X0 / ENEMY_X1 / ENEMY_X2, default 160 / 320 / 480: fixed left column of enemies 0..2.
REQ-004 Parameter PROJ_W / PROJ_H, default 4 / 8: projectile size in pixels.
REQ-005 clk  input  1  system clock, 50 MHz.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 next_x, next_y  input  10 each  coordinate of next pixel requested by VGA driver; held for two or more clk.
REQ-008 game_state  input  2  0=HOME, 1=UPDATE, 2=END; 3 treated as HOME.
REQ-009 user_x  input  10  player sprite left column.
REQ-010 enemy_y0, enemy_y1, enemy_y2  input  10 each  enemy sprite top rows.
REQ-011 enemy_alive  input  3  bit i set = enemy i drawn.
REQ-012 proj_x, proj_y  input  10 each  projectile top-left corner.
REQ-013 proj_valid  input  1  projectile drawn when set.
REQ-014 health  input  4  player health, 0..15.
REQ-015 color  output  8  RGB 3-3-2 pixel colour, to VGA driver colour input.
REQ-016 frame_tick  output  1  one-clk pulse per frame boundary.

Function
REQ-017 Frame boundary SHALL be the first clk on which next_y==480 and next_x==0 (rising edge of that condition, detected against a registered copy); frame_tick SHALL pulse high on the clk after detection.
REQ-018 At each frame boundary all position, alive, valid, health and game_state inputs SHALL be copied into shadow registers; rendering SHALL use only shadow values, so no tearing occurs mid-frame.
REQ-019 A 6-bit frame counter SHALL increment at each frame boundary and wrap 63->0.
REQ-020 Pipeline: stage 1 registers coordinates and per-object hit bits; stage 2 registers color; color for a given next_x/next_y SHALL be valid exactly 2 clk after it is presented.
REQ-021 Hit test: pixel (x,y) inside object at (ox,oy) iff ox<=x<ox+W and oy<=y<oy+H, with sums formed at 11 bits so objects near 640/480 never wrap to column/row 0.
REQ-022 Health bar hit: y<8 and x<health*16 (8-bit product); health=0 draws no bar.
REQ-023 Priority, highest first: projectile (YELLOW 8'hFC), enemy (RED 8'hE0), player (GREEN 8'h1C), health bar (WHITE 8'hFF), background.
REQ-024 Background: HOME 8'h02, UPDATE 8'h00, END 8'hE0 when frame counter bit 5 is 0 else 8'h00.
REQ-025 HOME draws background and player only; UPDATE draws all objects; END draws background and health bar only.
REQ-026 Pixels with x>=640 or y>=480 SHALL output 8'h00 regardless of state.
REQ-027 Simultaneous overlap of objects SHALL resolve strictly by REQ-023; unused enable bits suppress hits entirely.

Reset
REQ-028 On rst low: color=8'h00, frame_tick=0, frame counter=0, all shadow registers=0 (state HOME, nothing alive, proj_valid=0, health=0), pipeline registers cleared.
REQ-029 Reset released mid-frame: output is background only (HOME, player at column 0 row PLAYER_Y) until the next frame boundary loads real shadows.

Structure
REQ-030 Colour constants, game_state encodings and screen limits (640, 480) SHALL live in the shared game package also used by the top-level state machine.
REQ-031 One sub-module, rect_hit, SHALL implement the 11-bit rectangle test of REQ-021 and be instanced once per object.

Verification
REQ-032 UPDATE, user_x=100, pixel (105,445) -> color 8'h1C two clk later.
REQ-033 Enemy 1 alive at enemy_y1=445 overlapping projectile at (322,446), proj_valid=1; pixel (323,447) -> 8'hFC; clear proj_valid next frame -> 8'hE0.
REQ-034 health=3, pixel (47,4) -> 8'hFF; pixel (48,4) -> background 8'h00; health=0 -> no bar.
REQ-035 Change user_x from 100 to 300 mid-frame -> pixels unchanged until frame_tick, then sprite at 300.
REQ-036 END for 64 frames -> background 8'hE0 for frames 0-31 and 8'h00 for 32-63; pixel (700,10) -> 8'h00 always.
REQ-037 Assert rst mid-frame -> color 8'h00 immediately; after release, HOME background 8'h02 until first frame_tick.

Source files
------------

// File: rtl/sprite_renderer_pkg.sv
// Shared game package: screen limits, game_state encodings, colour constants,
// the per-frame shadow record and the background colour helper. Also used by
// the top-level game state machine so both sides agree on encodings.
package sprite_renderer_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // game_state encodings; 2'd3 is not produced but renders as HOME.
  localparam logic [1:0] GS_HOME   = 2'd0;
  localparam logic [1:0] GS_UPDATE = 2'd1;
  localparam logic [1:0] GS_END    = 2'd2;

  // RGB 3-3-2 colours.
  localparam logic [7:0] COL_BLACK   = 8'h00;
  localparam logic [7:0] COL_HOME_BG = 8'h02;
  localparam logic [7:0] COL_YELLOW  = 8'hFC;
  localparam logic [7:0] COL_RED     = 8'hE0;
  localparam logic [7:0] COL_GREEN   = 8'h1C;
  localparam logic [7:0] COL_WHITE   = 8'hFF;

  // Everything the renderer samples once per frame.
  typedef struct packed {
    logic [1:0] game_state;
    logic [9:0] user_x;
    logic [9:0] enemy_y0;
    logic [9:0] enemy_y1;
    logic [9:0] enemy_y2;
    logic [2:0] enemy_alive;
    logic [9:0] proj_x;
    logic [9:0] proj_y;
    logic       proj_valid;
    logic [3:0] health;
  } shadow_t;

  // Background per state; END blinks red/black on frame counter bit 5.
  function automatic logic [7:0] bg_color(input logic [1:0] state, input logic blink_off);
    logic [7:0] c;
    case (state)
      GS_UPDATE: c = COL_BLACK;
      GS_END:    c = blink_off ? COL_BLACK : COL_RED;
      default:   c = COL_HOME_BG;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rect_hit.sv
// rect_hit: combinational point-in-rectangle test.
// Ports:
//   i_x, i_y   pixel coordinate under test
//   i_ox, i_oy rectangle top-left corner
//   i_en       object enable; low suppresses the hit entirely
//   o_hit      high when ox <= x < ox+W and oy <= y < oy+H
// Right/bottom edges are formed at 11 bits so an object near the 10-bit limit
// never wraps around to column/row 0.
module rect_hit #(
  parameter int unsigned W = 16,
  parameter int unsigned H = 16
) (
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic [9:0] i_ox,
  input  logic [9:0] i_oy,
  input  logic       i_en,
  output logic       o_hit
);

  logic [10:0] w_x_end;
  logic [10:0] w_y_end;

  assign w_x_end = {1'b0, i_ox} + 11'(W);
  assign w_y_end = {1'b0, i_oy} + 11'(H);

  assign o_hit = i_en
               && (i_x >= i_ox) && ({1'b0, i_x} < w_x_end)
               && (i_y >= i_oy) && ({1'b0, i_y} < w_y_end);

endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: per-pixel colour generator for the VGA driver.
// Ports:
//   clk, rst                 50 MHz clock, asynchronous active-low reset
//   i_next_x, i_next_y       next pixel requested by the VGA driver
//   i_game_state             HOME / UPDATE / END (3 renders as HOME)
//   i_user_x                 player left column (row fixed at PLAYER_Y)
//   i_enemy_y0..2            enemy top rows (columns fixed at ENEMY_X0..2)
//   i_enemy_alive            per-enemy draw enable
//   i_proj_x, i_proj_y       projectile top-left, drawn when i_proj_valid
//   i_health                 health bar length in 16-pixel units
//   o_color                  RGB 3-3-2, valid 2 clk after the coordinate
//   o_frame_tick             one-clk pulse after each frame boundary
// All object inputs are captured into shadow registers at the frame boundary
// so a frame is rendered from one consistent snapshot.
module sprite_renderer
  import sprite_renderer_pkg::*;
#(
  parameter int unsigned PLAYER_Y = 440,
  parameter int unsigned SPR_W    = 16,
  parameter int unsigned SPR_H    = 16,
  parameter int unsigned ENEMY_X0 = 160,
  parameter int unsigned ENEMY_X1 = 320,
  parameter int unsigned ENEMY_X2 = 480,
  parameter int unsigned PROJ_W   = 4,
  parameter int unsigned PROJ_H   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_next_x,
  input  logic [9:0] i_next_y,
  input  logic [1:0] i_game_state,
  input  logic [9:0] i_user_x,
  input  logic [9:0] i_enemy_y0,
  input  logic [9:0] i_enemy_y1,
  input  logic [9:0] i_enemy_y2,
  input  logic [2:0] i_enemy_alive,
  input  logic [9:0] i_proj_x,
  input  logic [9:0] i_proj_y,
  input  logic       i_proj_valid,
  input  logic [3:0] i_health,
  output logic [7:0] o_color,
  output logic       o_frame_tick
);

  // ---------------------------------------------------------------------------
  // Frame boundary detection and shadow capture
  // ---------------------------------------------------------------------------
  logic    w_frame_cond;
  logic    w_frame_start;
  logic    r_frame_cond;
  logic    r_frame_tick;
  logic [5:0] r_frame_cnt;
  shadow_t w_live;
  shadow_t r_shadow;

  assign w_frame_cond  = (i_next_y == 10'(SCREEN_H)) && (i_next_x == 10'd0);
  // Rising edge only: the driver holds the coordinate for several clk.
  assign w_frame_start = w_frame_cond && !r_frame_cond;

  always_comb begin
    w_live             = '0;
    w_live.game_state  = i_game_state;
    w_live.user_x      = i_user_x;
    w_live.enemy_y0    = i_enemy_y0;
    w_live.enemy_y1    = i_enemy_y1;
    w_live.enemy_y2    = i_enemy_y2;
    w_live.enemy_alive = i_enemy_alive;
    w_live.proj_x      = i_proj_x;
    w_live.proj_y      = i_proj_y;
    w_live.proj_valid  = i_proj_valid;
    w_live.health      = i_health;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cond <= 1'b0;
      r_frame_tick <= 1'b0;
      r_frame_cnt  <= 6'd0;
      r_shadow     <= '0;
    end else begin
      r_frame_cond <= w_frame_cond;
      r_frame_tick <= w_frame_start;
      if (w_frame_start) begin
        r_shadow    <= w_live;
        r_frame_cnt <= r_frame_cnt + 6'd1;
      end
    end
  end

  assign o_frame_tick = r_frame_tick;

  // ---------------------------------------------------------------------------
  // Per-state object enables
  // ---------------------------------------------------------------------------
  logic       w_is_update;
  logic       w_is_end;
  logic       w_en_player;
  logic       w_en_proj;
  logic       w_en_bar;
  logic [2:0] w_en_enemy;

  assign w_is_update = (r_shadow.game_state == GS_UPDATE);
  assign w_is_end    = (r_shadow.game_state == GS_END);
  // Player is drawn in HOME (including encoding 3) and UPDATE, never in END.
  assign w_en_player = !w_is_end;
  assign w_en_proj   = w_is_update && r_shadow.proj_valid;
  assign w_en_enemy  = {3{w_is_update}} & r_shadow.enemy_alive;
  assign w_en_bar    = w_is_update || w_is_end;

  // ---------------------------------------------------------------------------
  // Hit tests (combinational, ahead of stage 1)
  // ---------------------------------------------------------------------------
  logic       w_hit_player;
  logic       w_hit_proj;
  logic [2:0] w_hit_enemy;
  logic       w_hit_bar;
  logic [7:0] w_bar_len;

  rect_hit #(.W(SPR_W), .H(SPR_H)) u_hit_player (
    .i_x   (i_next_x),
    .i_y   (i_next_y),
    .i_ox  (r_shadow.user_x),
    .i_oy  (10'(PLAYER_Y)),
    .i_en  (w_en_player),
    .o_hit (w_hit_player)
  );

  rect_hit #(.W(SPR_W), .H(SPR_H)) u_hit_enemy0 (
    .i_x   (i_next_x),
    .i_y   (i_next_y),
    .i_ox  (10'(ENEMY_X0)),
    .i_oy  (r_shadow.enemy_y0),
    .i_en  (w_en_enemy[0]),
    .o_hit (w_hit_enemy[0])
  );

  rect_hit #(.W(SPR_W), .H(SPR_H)) u_hit_enemy1 (
    .i_x   (i_next_x),
    .i_y   (i_next_y),
    .i_ox  (10'(ENEMY_X1)),
    .i_oy  (r_shadow.enemy_y1),
    .i_en  (w_en_enemy[1]),
    .o_hit (w_hit_enemy[1])
  );

  rect_hit #(.W(SPR_W), .H(SPR_H)) u_hit_enemy2 (
    .i_x   (i_next_x),
    .i_y   (i_next_y),
    .i_ox  (10'(ENEMY_X2)),
    .i_oy  (r_shadow.enemy_y2),
    .i_en  (w_en_enemy[2]),
    .o_hit (w_hit_enemy[2])
  );

  rect_hit #(.W(PROJ_W), .H(PROJ_H)) u_hit_proj (
    .i_x   (i_next_x),
    .i_y   (i_next_y),
    .i_ox  (r_shadow.proj_x),
    .i_oy  (r_shadow.proj_y),
    .i_en  (w_en_proj),
    .o_hit (w_hit_proj)
  );

  // Health bar is health*16 pixels wide along the top 8 rows; 15*16 fits 8 bits.
  assign w_bar_len = {r_shadow.health, 4'b0000};
  assign w_hit_bar = w_en_bar && (i_next_y < 10'd8) && (i_next_x < {2'b00, w_bar_len});

  // ---------------------------------------------------------------------------
  // Stage 1: coordinates and hit bits
  // ---------------------------------------------------------------------------
  logic [9:0] r_x_s1;
  logic [9:0] r_y_s1;
  logic       r_hit_player_s1;
  logic       r_hit_enemy_s1;
  logic       r_hit_proj_s1;
  logic       r_hit_bar_s1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x_s1          <= 10'd0;
      r_y_s1          <= 10'd0;
      r_hit_player_s1 <= 1'b0;
      r_hit_enemy_s1  <= 1'b0;
      r_hit_proj_s1   <= 1'b0;
      r_hit_bar_s1    <= 1'b0;
    end else begin
      r_x_s1          <= i_next_x;
      r_y_s1          <= i_next_y;
      r_hit_player_s1 <= w_hit_player;
      r_hit_enemy_s1  <= |w_hit_enemy;
      r_hit_proj_s1   <= w_hit_proj;
      r_hit_bar_s1    <= w_hit_bar;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: priority resolve and colour register
  // ---------------------------------------------------------------------------
  logic [7:0] w_color;
  logic       w_offscreen;
  logic [7:0] r_color;

  assign w_offscreen = (r_x_s1 >= 10'(SCREEN_W)) || (r_y_s1 >= 10'(SCREEN_H));

  // Written lowest priority first so each later layer overrides the earlier.
  always_comb begin
    w_color = bg_color(r_shadow.game_state, r_frame_cnt[5]);
    if (r_hit_bar_s1)    w_color = COL_WHITE;
    if (r_hit_player_s1) w_color = COL_GREEN;
    if (r_hit_enemy_s1)  w_color = COL_RED;
    if (r_hit_proj_s1)   w_color = COL_YELLOW;
    if (w_offscreen)     w_color = COL_BLACK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_color <= COL_BLACK;
    end else begin
      r_color <= w_color;
    end
  end

  assign o_color = r_color;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: reset state, pipeline latency, object
// hits and edges, priority, shadow timing, END blink, off-screen and mid-frame
// reset. Expected colours are hand-derived from object geometry.
module tb_sprite_renderer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] next_x, next_y;
  logic [1:0] game_state;
  logic [9:0] user_x;
  logic [9:0] enemy_y0, enemy_y1, enemy_y2;
  logic [2:0] enemy_alive;
  logic [9:0] proj_x, proj_y;
  logic       proj_valid;
  logic [3:0] health;
  logic [7:0] color;
  logic       frame_tick;

  int n_checks  = 0;
  int n_fail    = 0;
  int frame_cnt = 0;  // model of the 6-bit frame counter

  always #10 clk = ~clk;

  sprite_renderer dut (
    .clk           (clk),
    .rst           (rst),
    .i_next_x      (next_x),
    .i_next_y      (next_y),
    .i_game_state  (game_state),
    .i_user_x      (user_x),
    .i_enemy_y0    (enemy_y0),
    .i_enemy_y1    (enemy_y1),
    .i_enemy_y2    (enemy_y2),
    .i_enemy_alive (enemy_alive),
    .i_proj_x      (proj_x),
    .i_proj_y      (proj_y),
    .i_proj_valid  (proj_valid),
    .i_health      (health),
    .o_color       (color),
    .o_frame_tick  (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present a pixel, then sample the colour exactly two rising edges later.
  task automatic px(input string tag, input int x, input int y, input logic [7:0] exp);
    @(negedge clk);
    next_x = 10'(x);
    next_y = 10'(y);
    repeat (2) @(posedge clk);
    #1;
    check(tag, 32'(color), 32'(exp));
  endtask

  // Drive the frame-boundary coordinate and check the one-clk tick.
  task automatic do_frame();
    @(negedge clk);
    next_x = 10'd0;
    next_y = 10'd480;
    @(posedge clk);
    #1;
    check("frame_tick_hi", 32'(frame_tick), 32'd1);
    frame_cnt = (frame_cnt + 1) % 64;
    @(negedge clk);
    next_y = 10'd0;
    @(posedge clk);
    #1;
    check("frame_tick_lo", 32'(frame_tick), 32'd0);
  endtask

  initial begin
    rst         = 1'b0;
    next_x      = 10'd0;
    next_y      = 10'd0;
    game_state  = 2'd0;
    user_x      = 10'd0;
    enemy_y0    = 10'd0;
    enemy_y1    = 10'd0;
    enemy_y2    = 10'd0;
    enemy_alive = 3'b000;
    proj_x      = 10'd0;
    proj_y      = 10'd0;
    proj_valid  = 1'b0;
    health      = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_color", 32'(color), 32'h00);
    check("rst_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset shadows: HOME, player at column 0 row 440.
    px("home_bg_rst", 300, 100, 8'h02);
    px("home_player_rst", 5, 445, 8'h1C);

    // UPDATE, player at 100, health 3.
    game_state = 2'd1;
    user_x     = 10'd100;
    health     = 4'd3;
    // Not visible until the frame boundary.
    px("pre_frame_bg", 300, 100, 8'h02);
    do_frame();
    px("player_hit", 105, 445, 8'h1C);
    px("player_tl", 100, 440, 8'h1C);
    px("player_right_edge", 116, 445, 8'h00);
    px("player_left_edge", 99, 445, 8'h00);
    px("player_bottom_edge", 105, 456, 8'h00);
    px("bar_last", 47, 4, 8'hFF);
    px("bar_past", 48, 4, 8'h00);
    px("bar_row8", 10, 8, 8'h00);

    // Mid-frame change: old snapshot holds until the next boundary.
    user_x = 10'd300;
    health = 4'd0;
    px("tear_old_pos", 105, 445, 8'h1C);
    px("tear_new_pos", 305, 445, 8'h00);
    px("tear_old_bar", 10, 4, 8'hFF);
    do_frame();
    px("moved_new_pos", 305, 445, 8'h1C);
    px("moved_old_pos", 105, 445, 8'h00);
    px("health0_nobar", 0, 0, 8'h00);

    // Priority: projectile over enemy 1 over player; enemy 0 over bar.
    user_x      = 10'd318;
    health      = 4'd15;
    enemy_alive = 3'b011;
    enemy_y0    = 10'd0;
    enemy_y1    = 10'd445;
    enemy_y2    = 10'd200;
    proj_x      = 10'd322;
    proj_y      = 10'd446;
    proj_valid  = 1'b1;
    do_frame();
    px("proj_over_enemy", 323, 447, 8'hFC);
    px("enemy_over_player", 330, 450, 8'hE0);
    px("player_only", 319, 442, 8'h1C);
    px("enemy_over_bar", 165, 4, 8'hE0);
    px("bar_only", 10, 4, 8'hFF);
    px("dead_enemy2", 485, 205, 8'h00);
    proj_valid = 1'b0;
    do_frame();
    px("proj_cleared", 323, 447, 8'hE0);

    // Projectile at the right screen edge.
    proj_x     = 10'd638;
    proj_y     = 10'd100;
    proj_valid = 1'b1;
    do_frame();
    px("proj_edge_in", 639, 101, 8'hFC);
    px("proj_edge_off", 640, 101, 8'h00);
    px("proj_left_edge", 637, 101, 8'h00);
    px("offscreen_y", 10, 490, 8'h00);

    // HOME via encoding 3: player drawn, enemies/projectile/bar suppressed.
    game_state = 2'd3;
    do_frame();
    px("st3_bg", 300, 100, 8'h02);
    px("st3_enemy_off", 165, 4, 8'h02);
    px("st3_proj_off", 639, 101, 8'h02);
    px("st3_player", 319, 442, 8'h1C);

    // END: 64 frames of blinking background; only the bar is drawn.
    game_state = 2'd2;
    do_frame();
    px("end_player_off", 319, 442, (frame_cnt >= 32) ? 8'h00 : 8'hE0);
    px("end_bar", 10, 4, 8'hFF);
    for (int i = 0; i < 64; i++) begin
      do_frame();
      px("end_blink", 300, 200, (frame_cnt >= 32) ? 8'h00 : 8'hE0);
    end
    px("end_offscreen", 700, 10, 8'h00);

    // Mid-frame reset clears colour at once; HOME until the next boundary.
    px("pre_rst_bar", 10, 4, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_color", 32'(color), 32'h00);
    check("midrst_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst       = 1'b1;
    frame_cnt = 0;
    px("post_rst_bg", 300, 100, 8'h02);
    px("post_rst_player", 5, 445, 8'h1C);
    do_frame();
    px("post_rst_end_bg", 300, 100, 8'hE0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
